psi_twist_loader: RTL and testbench

PSI_TWIST_LOADER -- requirements
Module: psi_twist_loader

---
 rtl/psi_twist_loader.sv | 142 ++++++++++++++
 tb/tb_psi_twist_loader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/psi_twist_loader.sv
// Serial-to-8-lane loader that applies the psi twist (in_data * in_psi mod Q) before a radix-8 butterfly.
// Define PSI_TWIST_BYPASS_EN to pass in_data through unmodified with identical latency and handshake.
module psi_twist_loader #(
    parameter int WIDTH = 18,
    parameter int Q     = 12289
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [WIDTH-1:0]     in_psi,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*WIDTH-1:0]   out_frame
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           acc_cnt_q, acc_cnt_d;
    logic [2:0]           wr_cnt_q, wr_cnt_d;
    logic                 s0_valid_q, s0_valid_d;
    logic [WIDTH-1:0]     s0_data_q, s0_data_d;
    logic                 s1_valid_q, s1_valid_d;
    logic [8*WIDTH-1:0]   frame_q, frame_d;
    logic                 accept;
    logic [WIDTH-1:0]     lane_val;

`ifdef PSI_TWIST_BYPASS_EN
    logic [WIDTH-1:0]     s1_word_q, s1_word_d;
    logic                 unused_psi;

    assign unused_psi = ^in_psi;
    assign lane_val   = s1_word_q;

    always_comb begin
        s1_word_d = s1_word_q;
        if (s0_valid_q) begin
            s1_word_d = s0_data_q;
        end
    end
`else
    localparam logic [2*WIDTH-1:0] QW = (2*WIDTH)'(Q);

    logic [WIDTH-1:0]     s0_psi_q, s0_psi_d;
    logic [2*WIDTH-1:0]   s1_word_q, s1_word_d;

    // Full-width product keeps the reduction exact even for operands >= Q.
    assign lane_val = WIDTH'(s1_word_q % QW);

    always_comb begin
        s0_psi_d  = s0_psi_q;
        s1_word_d = s1_word_q;
        if (accept) begin
            s0_psi_d = in_psi;
        end
        if (s0_valid_q) begin
            s1_word_d = {{WIDTH{1'b0}}, s0_data_q} * {{WIDTH{1'b0}}, s0_psi_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_psi_q <= '0;
        end else begin
            s0_psi_q <= s0_psi_d;
        end
    end
`endif

    // Gating with rst_n keeps in_ready low throughout reset and high immediately on release.
    assign in_ready  = rst_n && (state_q == FILL) && (acc_cnt_q < 4'd8);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == HOLD);
    assign out_frame = frame_q;

    always_comb begin
        state_d    = state_q;
        acc_cnt_d  = acc_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        s0_valid_d = accept;
        s0_data_d  = s0_data_q;
        s1_valid_d = s0_valid_q;
        frame_d    = frame_q;

        if (accept) begin
            s0_data_d = in_data;
            acc_cnt_d = acc_cnt_q + 4'd1;
        end

        case (state_q)
            FILL: begin
                if (s1_valid_q) begin
                    for (int unsigned k = 0; k < 8; k++) begin
                        if (wr_cnt_q == 3'(k)) begin
                            frame_d[k*WIDTH +: WIDTH] = lane_val;
                        end
                    end
                    wr_cnt_d = wr_cnt_q + 3'd1;
                    if (wr_cnt_q == 3'd7) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d   = FILL;
                    acc_cnt_d = '0;
                    wr_cnt_d  = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            acc_cnt_q  <= '0;
            wr_cnt_q   <= '0;
            s0_valid_q <= 1'b0;
            s0_data_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_word_q  <= '0;
            frame_q    <= '0;
        end else begin
            state_q    <= state_d;
            acc_cnt_q  <= acc_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            s0_valid_q <= s0_valid_d;
            s0_data_q  <= s0_data_d;
            s1_valid_q <= s1_valid_d;
            s1_word_q  <= s1_word_d;
            frame_q    <= frame_d;
        end
    end

endmodule

// File: tb/tb_psi_twist_loader.sv
// Directed-plus-random bench for psi_twist_loader; lane values come from a plain arithmetic model.
module tb_psi_twist_loader;

    localparam int WIDTH = 18;
    localparam int Q     = 12289;
    localparam int FW    = 8 * WIDTH;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic [WIDTH-1:0]  in_psi;
    logic              out_valid;
    logic              out_ready;
    logic [FW-1:0]     out_frame;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    psi_twist_loader #(.WIDTH(WIDTH), .Q(Q)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_psi    (in_psi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_frame (out_frame)
    );

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] p);
        logic [63:0] prod;
`ifdef PSI_TWIST_BYPASS_EN
        prod = {46'b0, p};
        prod = 64'(d);
        return WIDTH'(prod);
`else
        prod = {46'b0, d} * {46'b0, p};
        return WIDTH'(prod % 64'(Q));
`endif
    endfunction

    function automatic logic [WIDTH-1:0] rnd_op();
        case ($urandom_range(0, 3))
            0:       return WIDTH'(Q - 1);
            1:       return '1;
            2:       return WIDTH'($urandom_range(0, Q - 1));
            default: return WIDTH'($urandom);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] p, output int waited);
        logic rdy;
        rdy      = 1'b0;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_psi   = p;
        for (int i = 0; i < 64; i++) begin
            rdy = in_ready;
            step();
            waited++;
            if (rdy) break;
        end
        chk("accept", FW'(rdy), FW'(1));
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom);
        in_psi   = WIDTH'($urandom);
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] d[8], input logic [WIDTH-1:0] p[8],
                              input int gap_mode, output logic [FW-1:0] exp, output int total);
        int w;
        total = 0;
        exp   = '0;
        for (int n = 0; n < 8; n++) begin
            send(d[n], p[n], w);
            total += w;
            exp[n*WIDTH +: WIDTH] = model(d[n], p[n]);
            if (gap_mode == 1 && n < 7) step();
            if (gap_mode == 2) repeat ($urandom_range(0, 3)) step();
        end
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 64; i++) begin
            if (out_valid) break;
            step();
        end
        chk("out_valid_rise", FW'(out_valid), FW'(1));
    endtask

    task automatic receive(input string tag, input logic [FW-1:0] exp, input int hold);
        wait_valid();
        chk(tag, out_frame, exp);
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_stable", out_frame, exp);
        end
        out_ready = 1'b1;
        step();
        chk("ov_after_hs", FW'(out_valid), FW'(0));
        out_ready = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_in_ready", FW'(in_ready), FW'(0));
        chk("rst_out_valid", FW'(out_valid), FW'(0));
        chk("rst_out_frame", out_frame, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_in_ready", FW'(in_ready), FW'(1));
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] d[8];
        logic [WIDTH-1:0] p[8];
        logic [FW-1:0]    exp, exp_base, const_frame, prev;
        int               total, w;

        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        in_psi    = '0;
        rst_n     = 1'b1;
        #1;
        apply_reset();

        // Basic twist, back-to-back, out_ready held high; check latency and handshake timing.
        for (int n = 0; n < 8; n++) begin
            d[n] = WIDTH'(n + 2);
            p[n] = WIDTH'(3);
        end
        out_ready = 1'b1;
        send_frame(d, p, 0, exp_base, total);
        chk("b2b_accept_edges", FW'(total), FW'(8));
        step();
        chk("ov_low_1_edge", FW'(out_valid), FW'(0));
        chk("rdy_low_full", FW'(in_ready), FW'(0));
        step();
        chk("ov_high_2_edges", FW'(out_valid), FW'(1));
        chk("basic_frame", out_frame, exp_base);
`ifndef PSI_TWIST_BYPASS_EN
        const_frame = '0;
        for (int k = 0; k < 8; k++) const_frame[k*WIDTH +: WIDTH] = WIDTH'(3 * (k + 2));
        chk("basic_frame_const", out_frame, const_frame);
`endif
        step();
        chk("basic_ov_after_hs", FW'(out_valid), FW'(0));
        chk("basic_rdy_after_hs", FW'(in_ready), FW'(1));
        out_ready = 1'b0;

        // Reduction boundaries.
        d = '{18'd12288, 18'd20000, 18'd0, 18'd12289, 18'h3FFFF, 18'd20000, 18'd24578, 18'd5};
        p = '{18'd12288, 18'd1, 18'd777, 18'd5, 18'h3FFFF, 18'd5, 18'd3, 18'd0};
        send_frame(d, p, 0, exp, total);
        wait_valid();
`ifdef PSI_TWIST_BYPASS_EN
        chk("bypass_lane5", FW'(out_frame[5*WIDTH +: WIDTH]), FW'(20000));
`else
        chk("red_lane0", FW'(out_frame[0 +: WIDTH]), FW'(1));
        chk("red_lane1", FW'(out_frame[WIDTH +: WIDTH]), FW'(7711));
`endif
        receive("reduction_frame", exp, 0);

        // Backpressure: 20 stalled cycles with in_valid asserted and garbage inputs.
        for (int n = 0; n < 8; n++) begin
            d[n] = rnd_op();
            p[n] = rnd_op();
        end
        send_frame(d, p, 0, exp, total);
        wait_valid();
        chk("bp_frame", out_frame, exp);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'($urandom);
            in_psi   = WIDTH'($urandom);
            step();
            chk("bp_stable", out_frame, exp);
            chk("bp_rdy_low", FW'(in_ready), FW'(0));
            chk("bp_ov_high", FW'(out_valid), FW'(1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        prev = exp;
        chk("bp_ov_after_hs", FW'(out_valid), FW'(0));
        chk("bp_rdy_after_hs", FW'(in_ready), FW'(1));
        chk("fill_keeps_lanes", out_frame, prev);
        exp = '0;
        for (int n = 0; n < 8; n++) begin
            d[n] = rnd_op();
            p[n] = rnd_op();
            send(d[n], p[n], w);
            if (n == 0) chk("first_accept_after_hs", FW'(w), FW'(1));
            exp[n*WIDTH +: WIDTH] = model(d[n], p[n]);
        end
        receive("post_bp_frame", exp, 2);

        // Alternating in_valid gaps must reproduce the gapless frame.
        for (int n = 0; n < 8; n++) begin
            d[n] = WIDTH'(n + 2);
            p[n] = WIDTH'(3);
        end
        send_frame(d, p, 1, exp, total);
        receive("gap_frame", exp_base, 0);

        // Reset after 5 accepts discards the partial frame.
        for (int n = 0; n < 5; n++) send(rnd_op(), rnd_op(), w);
        apply_reset();
        for (int n = 0; n < 8; n++) begin
            d[n] = rnd_op();
            p[n] = rnd_op();
        end
        send_frame(d, p, 0, exp, total);
        receive("post_reset_frame", exp, 0);

        // Reset while holding a frame.
        send_frame(d, p, 2, exp, total);
        wait_valid();
        apply_reset();

        // Random frames with random gaps and backpressure.
        for (int f = 0; f < 8; f++) begin
            for (int n = 0; n < 8; n++) begin
                d[n] = rnd_op();
                p[n] = rnd_op();
            end
            send_frame(d, p, 2, exp, total);
            receive("rand_frame", exp, $urandom_range(0, 5));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
